// File: rtl/bufg_gt_pkg.sv
// Shared types and constants for the divided-clock-buffer control block.
// Holds the sequencing FSM state encoding, the DIV field width, the
// divide-by-1 code, and a helper that turns a cycle count into the load
// value for the 4-bit terminal-count down-counter.
package bufg_gt_pkg;

  localparam int DIV_W = 3;
  localparam logic [DIV_W-1:0] DIV_DIV1 = 3'b000;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_SETTLE
  } state_e;

  // A down-counter loaded with N-1 and leaving at zero spends N cycles in
  // its state. Out-of-range counts are clamped so the counter never wraps.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    if (cycles <= 1) return '0;
    if (cycles > (1 << CNT_W)) return '1;
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer.
// Ports:
//   clk        destination clock
//   clr_active async active-high reset; every stage is forced to RST_VAL
//   d          asynchronous input
//   q          synchronized output (last stage)
// Stage 0 samples d; q is the oldest stage, so latency is STAGES cycles.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic clr_active,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge clr_active) begin
    if (clr_active) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/bufg_gt_sync_ctrl.sv
// Control companion for a divided clock buffer: produces the buffer's CE,
// CLR and DIV inputs in the buffer input clock domain.
// Ports:
//   clk            buffer input clock
//   clr_active     async active-high reset
//   ce_in          async clock-enable request   -> ce_sync (synchronized)
//   clr_in         async clear request          -> clr_sync (synchronized, OR fsm clear)
//   div_req        requested divide code (ratio = code + 1)
//   div_req_valid  request valid; must be held until div_req_ready
//   div_req_ready  high in IDLE outside reset; handshake = valid && ready
//   ce_sync        CE to buffer
//   clr_sync       CLR to buffer
//   div_out        DIV to buffer; only updated while the FSM holds CLR high
//   busy           divide-change sequence in progress
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready for a request; a request equal to div_out is a no-op
// ST_CLR    | hold fsm_clr for CLR_HOLD cycles before touching DIV
// ST_LOAD   | fsm_clr still high; pending code is loaded into div_out
// ST_SETTLE | fsm_clr released; wait SETTLE cycles before next request
module bufg_gt_sync_ctrl
  import bufg_gt_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter int               CLR_HOLD    = 4,
  parameter int               SETTLE      = 2,
  parameter logic [DIV_W-1:0] DIV_RESET   = DIV_DIV1
) (
  input  logic             clk,
  input  logic             clr_active,
  input  logic             ce_in,
  input  logic             clr_in,
  input  logic [DIV_W-1:0] div_req,
  input  logic             div_req_valid,
  output logic             div_req_ready,
  output logic             ce_sync,
  output logic             clr_sync,
  output logic [DIV_W-1:0] div_out,
  output logic             busy
);

  logic ce_sync_raw;
  logic clr_sync_raw;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [DIV_W-1:0] pending_q, pending_d;
  logic [DIV_W-1:0] div_out_q, div_out_d;
  logic             fsm_clr_q, fsm_clr_d;
  logic             busy_q,    busy_d;

  sync_bit #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_ce_sync (
    .clk       (clk),
    .clr_active(clr_active),
    .d         (ce_in),
    .q         (ce_sync_raw)
  );

  // Resets to 1 so the buffer stays cleared until clr_in is seen low.
  sync_bit #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_clr_sync (
    .clk       (clk),
    .clr_active(clr_active),
    .d         (clr_in),
    .q         (clr_sync_raw)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    div_out_d = div_out_q;
    fsm_clr_d = fsm_clr_q;

    case (state_q)
      ST_IDLE: begin
        // Redundant requests are accepted without a clear pulse.
        if (div_req_valid && (div_req != div_out_q)) begin
          pending_d = div_req;
          cnt_d     = cnt_load(CLR_HOLD);
          fsm_clr_d = 1'b1;
          state_d   = ST_CLR;
        end
      end
      ST_CLR: begin
        if (cnt_q == '0) begin
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_LOAD: begin
        // div_out and fsm_clr update on the same edge, so DIV is stable
        // whenever the buffer sees CLR low.
        div_out_d = pending_q;
        fsm_clr_d = 1'b0;
        if (SETTLE == 0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_load(SETTLE);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        fsm_clr_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge clr_active) begin
    if (clr_active) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pending_q <= DIV_RESET;
      div_out_q <= DIV_RESET;
      fsm_clr_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      div_out_q <= div_out_d;
      fsm_clr_q <= fsm_clr_d;
      busy_q    <= busy_d;
    end
  end

  // Gated by clr_active so no handshake can complete during reset, and so
  // ready is already high in the first IDLE cycle after release.
  assign div_req_ready = (state_q == ST_IDLE) && !clr_active;

  assign ce_sync  = ce_sync_raw;
  assign clr_sync = clr_sync_raw | fsm_clr_q;
  assign div_out  = div_out_q;
  assign busy     = busy_q;

endmodule

// File: doc/bufg_gt_sync_ctrl.md
Name: bufg_gt_sync_ctrl

Overview:
Control-side companion to the divided clock buffer. It generates that buffer's CE, CLR and DIV inputs, registered and synchronized to the buffer's input clock. Asynchronous enable and clear requests pass through per-signal synchronizers. Divide-ratio changes are applied glitch-free: clear downstream, load new DIV, release. The block sits between the SoC clock-control registers and each divided-clock buffer instance.

Parameters:
SYNC_STAGES, 2, flop stages in each CE/CLR synchronizer; legal range 2..4.
CLR_HOLD, 4, cycles clr_sync is held high during a divide change before DIV is loaded; legal range 1..15.
SETTLE, 2, cycles after clr_sync release before a new request is accepted; legal range 0..15.
DIV_RESET, 3'b000, div_out value after reset (000 = divide-by-1).

Ports:
clk  input  1  buffer input clock (same net as buffer I).
clr_active  input  1  reset, asynchronous, active-high.
ce_in  input  1  asynchronous clock-enable request.
clr_in  input  1  asynchronous clear request.
div_req  input  3  requested divide code (ratio = code+1).
div_req_valid  input  1  divide-change request valid.
div_req_ready  output  1  high when a request is accepted this cycle.
ce_sync  output  1  synchronized CE to buffer.
clr_sync  output  1  synchronized CLR to buffer.
div_out  output  3  DIV to buffer; changes only while clr_sync=1.
busy  output  1  FSM not in IDLE.

Behaviour:
- Reset values while clr_active=1:
  - CE synchronizer flops = 0; CLR synchronizer flops = 1.
  - FSM = IDLE; counter = 0; div_out = DIV_RESET.
  - ce_sync = 0, clr_sync = 1, div_req_ready = 0, busy = 0.
- After reset release, clr_sync falls SYNC_STAGES cycles after clr_in is seen low, because the CLR synchronizer flushes its 1s.
- ce_sync = last stage of the CE synchronizer. Latency from ce_in is SYNC_STAGES cycles; ce_sync has no other gating.
- clr_sync = last CLR synchronizer stage OR fsm_clr. It is a registered output with no combinational path from inputs.
- FSM states:
  - IDLE:
    - div_req_ready = 1.
    - On div_req_valid && div_req == div_out: accept, stay in IDLE, no clear pulse.
    - On div_req_valid && div_req != div_out: accept, latch div_req into pending, go to CLR.
  - CLR:
    - fsm_clr = 1 for CLR_HOLD cycles, counted from the first CLR cycle.
    - Then go to LOAD.
  - LOAD (1 cycle):
    - div_out <= pending; fsm_clr stays 1.
    - Next state is SETTLE.
  - SETTLE:
    - fsm_clr = 0.
    - Wait SETTLE cycles, then go to IDLE. With SETTLE = 0, go straight to IDLE.
- div_req_ready = 1 only in IDLE and when clr_active = 0. A handshake occurs when valid && ready in the same cycle.
- Requests presented while busy are not accepted. The requester must hold valid until ready.
- div_out never changes while clr_sync = 0. It is updated only in LOAD, when fsm_clr = 1.
- External clear (clr_in) during CLR/LOAD/SETTLE does not disturb the FSM. clr_sync is the OR of both sources.
- Simultaneous ce_in toggle and divide change: the two are independent. CE keeps propagating through its synchronizer.
- clr_active asserted mid-sequence:
  - Immediately abandons the sequence.
  - div_out returns to DIV_RESET; the pending value is discarded.
  - clr_sync is forced to 1 asynchronously.
- Counters are 4 bits and saturate at terminal count; they never wrap.
- Total clr_sync-high span for one divide change = CLR_HOLD + 1 cycles. This assumes clr_in stays low.

Decomposition:
- Package bufg_gt_pkg holds:
  - FSM state enum: IDLE, CLR, LOAD, SETTLE.
  - DIV width constant: 3.
  - DIV_DIV1 constant: 3'b000.
- Natural sub-module: sync_bit, an N-stage synchronizer with a reset-value parameter. It is instantiated twice: CE with reset value 0, CLR with reset value 1.

Test Plan:
- Reset release with clr_in=0, ce_in=1, SYNC_STAGES=2:
  - clr_sync falls 2 cycles after release.
  - ce_sync rises 2 cycles after release.
  - div_out = 000 throughout.
- Divide change, div_out=000, div_req=3'b011 valid 1 cycle (CLR_HOLD=4, SETTLE=2):
  - ready=1 at accept; clr_sync high for 5 cycles.
  - div_out = 011 in the cycle after LOAD.
  - busy for 7 cycles; ready returns at cycle 8.
- Redundant request with div_req = div_out = 011:
  - Accepted in 1 cycle; clr_sync stays 0; busy stays 0.
- Request held valid during busy, with a second request 3'b101:
  - Not accepted until IDLE, then accepted.
  - div_out sequence is 011 -> 101; the two clear pulses do not overlap.
- clr_in pulse of 3 cycles while FSM in SETTLE:
  - clr_sync goes high after 2 cycles for 3 cycles.
  - FSM still reaches IDLE on schedule; div_out unchanged.
- clr_active asserted in the 2nd CLR cycle:
  - Immediately: clr_sync=1, div_out=000, busy=0.
  - After release: pending value not applied.
